// File: rtl/adder_pkg.sv
// Shared constants and FSM state encoding for the digit-serial adder.
package adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/add2_slice.sv
// Combinational 2-bit digit adder: {co, s} = x + y + ci.
module add2_slice (
    input  logic [1:0] x,
    input  logic [1:0] y,
    input  logic       ci,
    output logic [1:0] s,
    output logic       co
);

    logic [2:0] total;

    always_comb begin
        total = 3'(x) + 3'(y) + 3'(ci);
        s     = total[1:0];
        co    = total[2];
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: two bits per cycle, LSB digit first, result after WIDTH/2 cycles.
// Optional OVERFLOW_EN adds a registered two's-complement overflow output (ovf).
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned N  = WIDTH / 2;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [1:0]       dsum;
    logic             dco;

`ifdef OVERFLOW_EN
    logic sign_a;
    logic sign_b;
`endif

    add2_slice u_slice (
        .x  (a_sr[1:0]),
        .y  (b_sr[1:0]),
        .ci (carry),
        .s  (dsum),
        .co (dco)
    );

    // FSM, operand shifters, carry and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
            a_sr  <= '0;
            b_sr  <= '0;
`ifdef OVERFLOW_EN
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef OVERFLOW_EN
                        sign_a <= a[WIDTH-1];
                        sign_b <= b[WIDTH-1];
                        ovf    <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    // Result digits enter at the MSB end so the first digit lands at bit 0
                    sum   <= {dsum, sum[WIDTH-1:2]};
                    a_sr  <= {2'b00, a_sr[WIDTH-1:2]};
                    b_sr  <= {2'b00, b_sr[WIDTH-1:2]};
                    carry <= dco;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cout  <= dco;
`ifdef OVERFLOW_EN
                        ovf <= (sign_a == sign_b) && (dsum[1] != sign_a);
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder (WIDTH=8); define OVERFLOW_EN to also check ovf.
module tb_digit_serial_adder;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned N     = WIDTH / 2;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef OVERFLOW_EN
    logic             ovf;
`endif

    int checks   = 0;
    int failures = 0;

    digit_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef OVERFLOW_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_result(input string name, input logic [7:0] es, input logic ec, input logic eo);
        check({name, ".sum"}, 32'(sum), 32'(es));
        check({name, ".cout"}, 32'(cout), 32'(ec));
`ifdef OVERFLOW_EN
        check({name, ".ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("unreachable");
`endif
    endtask

    // One full operation with operand scrambling after acceptance
    task automatic do_op(input string name, input vec_t v);
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~v.a; b = ~v.b; cin = ~v.cin;
        check({name, ".busy0"}, 32'(busy), 32'd1);
        check({name, ".done0"}, 32'(done), 32'd0);
        for (int k = 1; k <= int'(N); k++) begin
            @(posedge clk);
            #1;
            if (k < int'(N)) begin
                if (busy !== 1'b1 || done !== 1'b0)
                    check({name, ".run"}, {30'd0, busy, done}, 32'b10);
            end else begin
                check({name, ".busy_done"}, {30'd0, busy, done}, 32'b01);
                check_result(name, v.exp_sum, v.exp_cout, v.exp_ovf);
            end
        end
        @(posedge clk);
        #1;
        check({name, ".done_clr"}, 32'(done), 32'd0);
        check_result({name, ".hold"}, v.exp_sum, v.exp_cout, v.exp_ovf);
    endtask

    initial begin
        int done_cnt;
        int t1, t2, ndone;
        logic [7:0] s1, s2;
        logic c1, c2;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check_result("reset", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;

        for (int i = 0; i < 8; i++) do_op($sformatf("vec%0d", i), vecs[i]);

        // Start pulsed during RUN with new operands must be ignored
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                done_cnt++;
                check_result("ignore", 8'h30, 1'b0, 1'b0);
            end
        end
        check("ignore.done_count", 32'(done_cnt), 32'd1);

        // Reset at digit 2 aborts without a done pulse
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check_result("abort", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_cnt++;
        end
        check("abort.no_done", 32'(done_cnt), 32'd0);
        do_op("after_abort", '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0});

        // Back-to-back with start held high
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 a = 8'hF0;
        t1 = -1; t2 = -1; ndone = 0;
        s1 = '0; s2 = '0; c1 = 1'b0; c2 = 1'b0;
        for (int k = 1; k <= 24 && ndone < 2; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (ndone == 0) begin t1 = k; s1 = sum; c1 = cout; end
                else begin t2 = k; s2 = sum; c2 = cout; start = 1'b0; end
                ndone++;
            end
        end
        start = 1'b0;
        check("b2b.count", 32'(ndone), 32'd2);
        check("b2b.first_time", 32'(t1), 32'd4);
        check("b2b.gap", 32'(t2 - t1), 32'd6);
        check("b2b.sum1", 32'(s1), 32'h30);
        check("b2b.cout1", 32'(c1), 32'd0);
        check("b2b.sum2", 32'(s2), 32'h10);
        check("b2b.cout2", 32'(c2), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("b2b.idle_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
